// File: rtl/epc_bus_frontend.sv
// EPC host bus front end for the bus32 register bank.
// Synchronises the asynchronous EPC strobes, latches address/data/byte
// enables, issues one single-cycle register request per EPC access and
// returns read data plus a ready flag. An ack timeout keeps a hung
// register bank from stalling the host bus.
module epc_bus_frontend #(
  parameter int                   datawidth      = 32,
  parameter int                   addrwidth      = 8,
  parameter int                   sync_stages    = 2,
  parameter int                   timeout_cycles = 255,
  parameter logic [datawidth-1:0] timeout_data   = 32'hDEAD_BEEF
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic [31:0]          epc_addr_in,
  input  logic [datawidth-1:0] epc_data_in,
  input  logic [3:0]           epc_be_in,
  input  logic                 epc_cs_n_in,
  input  logic                 epc_wr_n_in,
  input  logic                 epc_rd_n_in,
  output logic [datawidth-1:0] epc_data_out,
  output logic                 epc_rdy_out,
  output logic [addrwidth-1:0] reg_addr_out,
  output logic [datawidth-1:0] reg_wdata_out,
  output logic [3:0]           reg_be_out,
  output logic                 reg_wr_out,
  output logic                 reg_rd_out,
  input  logic [datawidth-1:0] reg_rdata_in,
  input  logic                 reg_ack_in,
  output logic                 timeout_out,
  output logic                 proto_err_out
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [15:0]          TO_LAST   = 16'(timeout_cycles - 1);
  localparam logic [datawidth-1:0] ZERO_DATA = {datawidth{1'b0}};

  // Strobe synchroniser chains; the last stage is the synced strobe.
  logic [sync_stages-1:0] r_cs_sync;
  logic [sync_stages-1:0] r_wr_sync;
  logic [sync_stages-1:0] r_rd_sync;
  logic                   w_cs_n;
  logic                   w_wr_n;
  logic                   w_rd_n;
  logic                   w_access;
  logic                   w_conflict;
  logic                   w_addr_unused;

  // Registered FSM state and outputs, with their next values.
  state_t                 r_state, w_state;
  logic [15:0]            r_cnt, w_cnt;
  logic                   r_is_read, w_is_read;
  logic                   r_proto_lock, w_proto_lock;
  logic [datawidth-1:0]   r_data, w_data;
  logic                   r_rdy, w_rdy;
  logic [addrwidth-1:0]   r_addr, w_addr;
  logic [datawidth-1:0]   r_wdata, w_wdata;
  logic [3:0]             r_be, w_be;
  logic                   r_wr, w_wr;
  logic                   r_rd, w_rd;
  logic                   r_timeout, w_timeout;
  logic                   r_proto_err, w_proto_err;

  assign w_cs_n        = r_cs_sync[sync_stages-1];
  assign w_wr_n        = r_wr_sync[sync_stages-1];
  assign w_rd_n        = r_rd_sync[sync_stages-1];
  assign w_access      = !w_cs_n && (w_wr_n != w_rd_n);
  assign w_conflict    = !w_cs_n && !w_wr_n && !w_rd_n;
  // Byte offset and upper address bits do not select a register word.
  assign w_addr_unused = ^{epc_addr_in[31:addrwidth+2], epc_addr_in[1:0]};

  // Shift the asynchronous strobes through the synchroniser chains (idle = 1).
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_cs_sync <= {sync_stages{1'b1}};
      r_wr_sync <= {sync_stages{1'b1}};
      r_rd_sync <= {sync_stages{1'b1}};
    end else begin
      r_cs_sync <= {r_cs_sync[sync_stages-2:0], epc_cs_n_in};
      r_wr_sync <= {r_wr_sync[sync_stages-2:0], epc_wr_n_in};
      r_rd_sync <= {r_rd_sync[sync_stages-2:0], epc_rd_n_in};
    end
  end

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_is_read    = r_is_read;
    w_proto_lock = r_proto_lock;
    w_data       = r_data;
    w_rdy        = r_rdy;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_be         = r_be;
    w_wr         = 1'b0;
    w_rd         = 1'b0;
    w_timeout    = 1'b0;
    w_proto_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_n) begin
          w_proto_lock = 1'b0;
        end else if (r_proto_lock) begin
          // Conflicting strobes already seen in this cs assertion: wait for cs=1.
          w_proto_lock = 1'b1;
        end else if (w_conflict) begin
          w_proto_err  = 1'b1;
          w_proto_lock = 1'b1;
        end else if (w_access) begin
          w_addr    = epc_addr_in[addrwidth+1:2];
          w_wdata   = epc_data_in;
          w_be      = epc_be_in;
          w_is_read = !w_rd_n;
          w_wr      = !w_wr_n;
          w_rd      = !w_rd_n;
          w_state   = ST_REQ;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_cnt = 16'd0;
        if (reg_ack_in) begin
          w_rdy   = 1'b1;
          w_data  = r_is_read ? reg_rdata_in : ZERO_DATA;
          w_state = ST_DONE;
        end else begin
          w_state = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (reg_ack_in) begin
          // An ack on the timeout cycle still wins.
          w_rdy   = 1'b1;
          w_data  = r_is_read ? reg_rdata_in : ZERO_DATA;
          w_state = ST_DONE;
        end else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_rdy     = 1'b1;
          w_data    = r_is_read ? timeout_data : ZERO_DATA;
          w_state   = ST_DONE;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      ST_DONE: begin
        if (w_cs_n) begin
          w_rdy   = 1'b0;
          w_data  = ZERO_DATA;
          w_state = ST_IDLE;
        end else begin
          w_state = ST_DONE;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // Register FSM state and all outputs; reset aborts any access in flight.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 16'd0;
      r_is_read    <= 1'b0;
      r_proto_lock <= 1'b0;
      r_data       <= ZERO_DATA;
      r_rdy        <= 1'b0;
      r_addr       <= {addrwidth{1'b0}};
      r_wdata      <= ZERO_DATA;
      r_be         <= 4'd0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_timeout    <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_is_read    <= w_is_read;
      r_proto_lock <= w_proto_lock;
      r_data       <= w_data;
      r_rdy        <= w_rdy;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_be         <= w_be;
      r_wr         <= w_wr;
      r_rd         <= w_rd;
      r_timeout    <= w_timeout;
      r_proto_err  <= w_proto_err;
    end
  end

  assign epc_data_out  = r_data;
  assign epc_rdy_out   = r_rdy;
  assign reg_addr_out  = r_addr;
  assign reg_wdata_out = r_wdata;
  assign reg_be_out    = r_be;
  assign reg_wr_out    = r_wr;
  assign reg_rd_out    = r_rd;
  assign timeout_out   = r_timeout;
  assign proto_err_out = r_proto_err;

endmodule

// File: tb/tb_epc_bus_frontend.sv
// Bench for epc_bus_frontend: a cycle timeline of expected outputs is built
// from the block's latency rules, and every cycle the DUT is compared to it.
module tb_epc_bus_frontend;
  localparam int TO    = 8;
  localparam int NCYC  = 1024;
  localparam int LAT   = 3;   // strobe edge to registered response (2 sync + 1)

  logic        clk = 1'b0;
  logic        reset_in;
  logic [31:0] epc_addr_in, epc_data_in, epc_data_out, reg_wdata_out, reg_rdata_in;
  logic [3:0]  epc_be_in, reg_be_out;
  logic        epc_cs_n_in, epc_wr_n_in, epc_rd_n_in, epc_rdy_out;
  logic [7:0]  reg_addr_out;
  logic        reg_wr_out, reg_rd_out, reg_ack_in, timeout_out, proto_err_out;

  epc_bus_frontend #(.timeout_cycles(TO)) dut (
    .clock_in(clk), .reset_in(reset_in),
    .epc_addr_in(epc_addr_in), .epc_data_in(epc_data_in), .epc_be_in(epc_be_in),
    .epc_cs_n_in(epc_cs_n_in), .epc_wr_n_in(epc_wr_n_in), .epc_rd_n_in(epc_rd_n_in),
    .epc_data_out(epc_data_out), .epc_rdy_out(epc_rdy_out),
    .reg_addr_out(reg_addr_out), .reg_wdata_out(reg_wdata_out), .reg_be_out(reg_be_out),
    .reg_wr_out(reg_wr_out), .reg_rd_out(reg_rd_out),
    .reg_rdata_in(reg_rdata_in), .reg_ack_in(reg_ack_in),
    .timeout_out(timeout_out), .proto_err_out(proto_err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected-output timeline, indexed by cycle number.
  logic        exp_wr [NCYC];
  logic        exp_rd [NCYC];
  logic        exp_rdy[NCYC];
  logic        exp_to [NCYC];
  logic        exp_pe [NCYC];
  logic [31:0] exp_dat[NCYC];
  logic [7:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_be;

  bit chk_en = 1'b0;
  int n_vec  = 0;
  int n_err  = 0;

  // Event counters and last-seen values, used for the literal checks.
  int          wr_pulses = 0, rd_pulses = 0, to_pulses = 0, pe_pulses = 0, rdy_rises = 0;
  int          last_req_cyc = 0, last_to_cyc = 0;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata, last_rdata;
  logic [3:0]  last_be;
  logic        prev_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the timeline, plus event bookkeeping.
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      chk("reg_wr_out",    32'(reg_wr_out),    32'(exp_wr[cyc]));
      chk("reg_rd_out",    32'(reg_rd_out),    32'(exp_rd[cyc]));
      chk("epc_rdy_out",   32'(epc_rdy_out),   32'(exp_rdy[cyc]));
      chk("timeout_out",   32'(timeout_out),   32'(exp_to[cyc]));
      chk("proto_err_out", 32'(proto_err_out), 32'(exp_pe[cyc]));
      chk("epc_data_out",  epc_data_out,       exp_dat[cyc]);
      if (exp_wr[cyc] || exp_rd[cyc]) begin
        chk("reg_addr_out", 32'(reg_addr_out), 32'(exp_addr));
        chk("reg_be_out",   32'(reg_be_out),   32'(exp_be));
        if (exp_wr[cyc]) chk("reg_wdata_out", reg_wdata_out, exp_wdata);
      end
    end
    if (reg_wr_out) wr_pulses++;
    if (reg_rd_out) rd_pulses++;
    if (reg_wr_out || reg_rd_out) begin
      last_req_cyc = cyc;
      last_addr    = reg_addr_out;
      last_wdata   = reg_wdata_out;
      last_be      = reg_be_out;
    end
    if (timeout_out) begin
      to_pulses++;
      last_to_cyc = cyc;
    end
    if (proto_err_out) pe_pulses++;
    if (epc_rdy_out && !prev_rdy) begin
      rdy_rises++;
      last_rdata = epc_data_out;
    end
    prev_rdy = epc_rdy_out;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One EPC access. ack_dly: cycles after the request the ack is driven
  // (0 = during the request cycle), or -1 for no ack at all.
  task automatic do_access(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int ack_dly, input logic [31:0] rdata,
                           input int hold, input bit toggle);
    int          req, rdy_s, cs_up;
    logic [31:0] d;
    req = cyc + LAT;
    if (is_wr) exp_wr[req] = 1'b1;
    else       exp_rd[req] = 1'b1;
    exp_addr  = addr[9:2];
    exp_wdata = wdata;
    exp_be    = be;
    if (ack_dly >= 0) begin
      rdy_s = req + ack_dly + 1;
      d     = is_wr ? 32'h0 : rdata;
    end else begin
      rdy_s = req + 1 + TO;
      exp_to[rdy_s] = 1'b1;
      d     = is_wr ? 32'h0 : 32'hDEAD_BEEF;
    end
    cs_up = rdy_s + hold;
    for (int i = rdy_s; i < cs_up + LAT; i++) begin
      exp_rdy[i] = 1'b1;
      exp_dat[i] = d;
    end
    epc_addr_in = addr;
    epc_data_in = wdata;
    epc_be_in   = be;
    epc_cs_n_in = 1'b0;
    if (is_wr) epc_wr_n_in = 1'b0;
    else       epc_rd_n_in = 1'b0;
    if (ack_dly >= 0) begin
      step(req + ack_dly - cyc);
      reg_rdata_in = rdata;
      reg_ack_in   = 1'b1;
      step(1);
      reg_ack_in   = 1'b0;
      reg_rdata_in = 32'h5555_AAAA;
    end
    if (toggle) begin
      step(rdy_s + 1 - cyc);
      epc_wr_n_in = 1'b1;
      step(2);
      epc_wr_n_in = 1'b0;
    end
    step(cs_up - cyc);
    epc_cs_n_in = 1'b1;
    epc_wr_n_in = 1'b1;
    epc_rd_n_in = 1'b1;
    epc_addr_in = 32'hFFFF_FFFF;
    epc_data_in = 32'h0BAD_0BAD;
    step(LAT);
  endtask

  int wr0, rd0, rr0, to0;

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      exp_wr[i] = 1'b0; exp_rd[i] = 1'b0; exp_rdy[i] = 1'b0;
      exp_to[i] = 1'b0; exp_pe[i] = 1'b0; exp_dat[i] = 32'h0;
    end
    exp_addr = 8'h0; exp_wdata = 32'h0; exp_be = 4'h0;
    reset_in = 1'b1;
    epc_addr_in = 32'h0; epc_data_in = 32'h0; epc_be_in = 4'h0;
    epc_cs_n_in = 1'b1; epc_wr_n_in = 1'b1; epc_rd_n_in = 1'b1;
    reg_rdata_in = 32'h5555_AAAA; reg_ack_in = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(2);
    reset_in = 1'b0;
    chk("rst reg_addr_out",  32'(reg_addr_out), 32'h0);
    chk("rst reg_wdata_out", reg_wdata_out,     32'h0);
    chk("rst reg_be_out",    32'(reg_be_out),   32'h0);
    chk("rst epc_data_out",  epc_data_out,      32'h0);
    step(3);

    // Write, ack two cycles after the request.
    do_access(1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 2, 32'h0, 4, 1'b0);
    chk("wr pulses",     32'(wr_pulses), 32'd1);
    chk("wr addr lit",   32'(last_addr), 32'h04);
    chk("wr wdata lit",  last_wdata,     32'hA5A5_1234);
    chk("wr be lit",     32'(last_be),   32'hF);
    chk("wr rdy rises",  32'(rdy_rises), 32'd1);

    // Read, ack during the request cycle.
    do_access(1'b0, 32'h0000_00FC, 32'h0, 4'hF, 0, 32'h1357_9BDF, 3, 1'b0);
    chk("rd addr lit",   32'(last_addr), 32'h3F);
    chk("rd data lit",   last_rdata,     32'h1357_9BDF);
    chk("rd no timeout", 32'(to_pulses), 32'd0);

    // Read that never gets an ack.
    do_access(1'b0, 32'h0000_0020, 32'h0, 4'h3, -1, 32'h0, 3, 1'b0);
    chk("to pulses",     32'(to_pulses), 32'd1);
    chk("to latency",    32'(last_to_cyc - last_req_cyc), 32'd9);
    chk("to data lit",   last_rdata,     32'hDEAD_BEEF);

    // Both strobes low for 10 cycles.
    wr0 = wr_pulses; rd0 = rd_pulses; rr0 = rdy_rises;
    exp_pe[cyc + LAT] = 1'b1;
    epc_cs_n_in = 1'b0; epc_wr_n_in = 1'b0; epc_rd_n_in = 1'b0;
    step(10);
    epc_cs_n_in = 1'b1; epc_wr_n_in = 1'b1; epc_rd_n_in = 1'b1;
    step(4);
    chk("pe pulses",     32'(pe_pulses),           32'd1);
    chk("pe no request", 32'(wr_pulses + rd_pulses), 32'(wr0 + rd0));
    chk("pe no rdy",     32'(rdy_rises),           32'(rr0));

    // Reset while waiting for an ack; the late ack must be ignored.
    rd0 = rd_pulses; rr0 = rdy_rises; to0 = to_pulses;
    exp_rd[cyc + LAT] = 1'b1;
    exp_addr = 8'h12; exp_be = 4'h1;
    epc_addr_in = 32'h0000_0048; epc_be_in = 4'h1;
    epc_cs_n_in = 1'b0; epc_rd_n_in = 1'b0;
    step(LAT + 2);
    reset_in = 1'b1; epc_cs_n_in = 1'b1; epc_rd_n_in = 1'b1;
    step(1);
    reset_in = 1'b0; reg_ack_in = 1'b1; reg_rdata_in = 32'h7777_7777;
    step(1);
    reg_ack_in = 1'b0; reg_rdata_in = 32'h5555_AAAA;
    step(TO + 6);
    chk("rst rd pulses", 32'(rd_pulses), 32'(rd0 + 1));
    chk("rst no rdy",    32'(rdy_rises), 32'(rr0));
    chk("rst no to",     32'(to_pulses), 32'(to0));
    do_access(1'b0, 32'h0000_0044, 32'h0, 4'h1, 1, 32'hCAFE_0001, 3, 1'b0);
    chk("post-rst rd",   last_rdata,     32'hCAFE_0001);
    chk("post-rst rdy",  32'(rdy_rises), 32'(rr0 + 1));

    // Back-to-back writes, wr_n toggled inside the first cs assertion.
    wr0 = wr_pulses; rr0 = rdy_rises;
    do_access(1'b1, 32'h0000_0008, 32'h1111_2222, 4'hC, 1, 32'h0, 6, 1'b1);
    do_access(1'b1, 32'h0000_000C, 32'h3333_4444, 4'h5, 3, 32'h0, 3, 1'b0);
    chk("b2b wr pulses", 32'(wr_pulses), 32'(wr0 + 2));
    chk("b2b rdy rises", 32'(rdy_rises), 32'(rr0 + 2));
    chk("b2b last addr", 32'(last_addr), 32'h03);

    step(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
